// File: rtl/point_link_arbiter.sv
// Round-robin arbiter that frames local requester bursts onto a point-to-point link
// as one header word followed by the requested number of payload words.
module point_link_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [4*NREQ-1:0]       req_len,
   input  logic [WIDTH*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]         req_pop,
   input  logic                    link_hold,
   output logic [1:0]              link_tag,
   output logic [WIDTH-1:0]        link_data,
   output logic                    busy,
   output logic [3:0]              cur_src
);

   typedef enum logic {
      IDLE = 1'b0,
      DATA = 1'b1
   } state_t;

   localparam logic [1:0] TAG_IDLE = 2'b00;
   localparam logic [1:0] TAG_HDR  = 2'b01;
   localparam logic [1:0] TAG_PAY  = 2'b10;
   localparam logic [1:0] TAG_LAST = 2'b11;

   state_t           state;
   logic [4:0]       cnt;
   logic [3:0]       ptr;
   logic             found;
   logic [3:0]       winner;
   logic [3:0]       win_len;
   logic [4:0]       win_cnt;
   logic [WIDTH-1:0] header;
   logic [WIDTH-1:0] payload;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req[(int'(ptr) + k) % NREQ]) begin
            found  = 1'b1;
            winner = 4'((int'(ptr) + k) % NREQ);
         end
      end
   end

   always_comb begin
      win_len     = req_len[4*winner +: 4];
      win_cnt     = (win_len == 4'd0) ? 5'd16 : {1'b0, win_len};
      header      = '0;
      header[7:4] = winner;
      header[3:0] = win_len;
      payload     = req_data[WIDTH*cur_src +: WIDTH];
   end

   always_comb begin
      req_pop = '0;
      if (state == DATA && !link_hold && !reset)
         req_pop = NREQ'(1) << cur_src;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         ptr       <= 4'(NREQ - 1);
         cur_src   <= '0;
         link_tag  <= TAG_IDLE;
         link_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!link_hold && found) begin
                  link_tag  <= TAG_HDR;
                  link_data <= header;
                  ptr       <= winner;
                  cur_src   <= winner;
                  cnt       <= win_cnt;
                  state     <= DATA;
               end else begin
                  link_tag  <= TAG_IDLE;
                  link_data <= '0;
               end
            end
            DATA: begin
               // A held link keeps every register frozen until the remote side drains.
               if (!link_hold) begin
                  link_data <= payload;
                  cnt       <= cnt - 5'd1;
                  if (cnt == 5'd1) begin
                     link_tag <= TAG_LAST;
                     state    <= IDLE;
                  end else begin
                     link_tag <= TAG_PAY;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_point_link_arbiter.sv
// Directed bench for point_link_arbiter: expected link words are queued as each
// step is driven and compared by a monitor one cycle-slot after every advancing edge.
module tb_point_link_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
   localparam int W     = WIDTH + 2;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [4*NREQ-1:0]     req_len;
   logic [WIDTH*NREQ-1:0] req_data;
   logic [NREQ-1:0]       req_pop;
   logic                  link_hold;
   logic [1:0]            link_tag;
   logic [WIDTH-1:0]      link_data;
   logic                  busy;
   logic [3:0]            cur_src;

   point_link_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset), .req(req), .req_len(req_len),
      .req_data(req_data), .req_pop(req_pop), .link_hold(link_hold),
      .link_tag(link_tag), .link_data(link_data), .busy(busy), .cur_src(cur_src)
   );

   always #5 clock = ~clock;

   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           exp_idx[NREQ];
   logic [7:0]   widx[NREQ];
   int           busy_cnt = 0;
   int           pop_cnt[NREQ];
   logic         adv_now;

   function automatic logic [WIDTH-1:0] word_of(int src, int k);
      return WIDTH'(32'hA000 | (src << 8) | (k & 8'hff));
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Requester model: each source walks through its own word sequence on every pop.
   always @(posedge clock) begin
      for (int i = 0; i < NREQ; i++) begin
         if (reset) widx[i] <= '0;
         else if (req_pop[i]) widx[i] <= widx[i] + 8'd1;
      end
   end

   always_comb begin
      req_data = '0;
      for (int i = 0; i < NREQ; i++)
         req_data[WIDTH*i +: WIDTH] = word_of(i, int'(widx[i]));
   end

   initial for (int i = 0; i < NREQ; i++) pop_cnt[i] = 0;

   always @(negedge clock) begin
      busy_cnt <= busy_cnt + int'(busy);
      for (int i = 0; i < NREQ; i++) pop_cnt[i] <= pop_cnt[i] + int'(req_pop[i]);
   end

   task automatic mon_check();
      logic [W-1:0] got;
      logic [W-1:0] e;
      got = {link_tag, link_data};
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("link_word", 32'(got), 32'(e));
      end else if (link_tag !== 2'b00) begin
         chk("unexpected_word", 32'(got), 32'd0);
      end
   endtask

   always begin
      @(posedge clock);
      adv_now = !reset && !link_hold;
      #1;
      if (adv_now) mon_check();
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic push_header(logic [3:0] src, logic [3:0] lenraw);
      exp_q.push_back({2'b01, WIDTH'({src, lenraw})});
   endtask

   task automatic push_payload(int src, bit last);
      exp_q.push_back({(last ? 2'b11 : 2'b10), word_of(src, exp_idx[src])});
      exp_idx[src]++;
   endtask

   task automatic push_burst(int src, logic [3:0] lenraw);
      int n;
      n = (lenraw == 4'd0) ? 16 : int'(lenraw);
      push_header(4'(src), lenraw);
      for (int j = 0; j < n; j++) push_payload(src, j == n - 1);
   endtask

   task automatic push_idle();
      exp_q.push_back('0);
   endtask

   task automatic wait_empty(int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) exp_idx[i] = 0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_len(int src, logic [3:0] l);
      req_len[4*src +: 4] = l;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0;
      int p0;
      int base;
      reset     = 1'b1;
      req       = '0;
      req_len   = '0;
      link_hold = 1'b0;
      do_reset();

      chk("reset_tag", 32'(link_tag), 32'd0);
      chk("reset_data", 32'(link_data), 32'd0);
      chk("reset_src", 32'(cur_src), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_pop", 32'(req_pop), 32'd0);

      // Single burst from requester 2, length 3, request dropped after grant.
      push_burst(2, 4'd3);
      push_idle();
      b0 = busy_cnt;
      p0 = pop_cnt[2];
      set_len(2, 4'd3);
      req = 4'b0100;
      tick();
      req = 4'b0000;
      chk("grant_pop", 32'(req_pop), 32'b0100);
      chk("grant_src", 32'(cur_src), 32'd2);
      chk("grant_busy", 32'(busy), 32'd1);
      wait_empty(20);
      chk("single_busy_cycles", 32'(busy_cnt - b0), 32'd3);
      chk("single_pop_cycles", 32'(pop_cnt[2] - p0), 32'd3);
      chk("idle_pop", 32'(req_pop), 32'd0);

      // Round robin with all four requesting length 1: 0,1,2,3,0 back to back.
      do_reset();
      req_len = 16'h1111;
      for (int s = 0; s < NREQ; s++) push_burst(s, 4'd1);
      push_burst(0, 4'd1);
      push_idle();
      req = 4'b1111;
      repeat (9) tick();
      req = 4'b0000;
      wait_empty(20);
      chk("rr_last_src", 32'(cur_src), 32'd0);

      // Length field 0 means a 16-word burst.
      push_burst(1, 4'd0);
      push_idle();
      p0 = pop_cnt[1];
      set_len(1, 4'd0);
      req = 4'b0010;
      tick();
      req = 4'b0000;
      wait_empty(40);
      chk("wrap_pop_cycles", 32'(pop_cnt[1] - p0), 32'd16);

      // Backpressure for 5 cycles after the second payload word.
      base = exp_idx[3];
      push_burst(3, 4'd4);
      push_idle();
      b0 = busy_cnt;
      p0 = pop_cnt[3];
      set_len(3, 4'd4);
      req = 4'b1000;
      tick();
      req = 4'b0000;
      tick();
      tick();
      link_hold = 1'b1;
      for (int h = 0; h < 5; h++) begin
         tick();
         chk("hold_tag", 32'(link_tag), 32'b10);
         chk("hold_data", 32'(link_data), 32'(word_of(3, base + 1)));
         chk("hold_pop", 32'(req_pop), 32'd0);
      end
      link_hold = 1'b0;
      wait_empty(20);
      chk("hold_pop_cycles", 32'(pop_cnt[3] - p0), 32'd4);
      chk("hold_busy_cycles", 32'(busy_cnt - b0), 32'd9);

      // Reset during the second payload word of an 8-word burst.
      push_header(4'd0, 4'd8);
      push_payload(0, 1'b0);
      push_payload(0, 1'b0);
      set_len(0, 4'd8);
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) exp_idx[i] = 0;
      #1;
      chk("reset_pop_mid", 32'(req_pop), 32'd0);
      tick();
      chk("abort_tag", 32'(link_tag), 32'd0);
      chk("abort_data", 32'(link_data), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      wait_empty(1);
      reset = 1'b0;
      set_len(0, 4'd2);
      set_len(3, 4'd1);
      push_burst(0, 4'd2);
      push_burst(3, 4'd1);
      push_idle();
      req = 4'b1001;
      tick();
      chk("post_reset_src", 32'(cur_src), 32'd0);
      repeat (3) tick();
      req = 4'b0000;
      wait_empty(20);

      // Early release of a length-2 request.
      push_burst(1, 4'd2);
      push_idle();
      p0 = pop_cnt[1];
      set_len(1, 4'd2);
      req = 4'b0010;
      tick();
      req = 4'b0000;
      wait_empty(20);
      chk("early_pop_cycles", 32'(pop_cnt[1] - p0), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
